// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_W      = 4;
  localparam int unsigned NUM_FLAGS = 4;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_SHL  = 4'h3,
    OP_SHR  = 4'h4,
    OP_INCA = 4'h5,
    OP_INCB = 4'h6,
    OP_DECA = 4'h7,
    OP_DECB = 4'h8,
    OP_EQ   = 4'h9,
    OP_GT   = 4'hA,
    OP_LT   = 4'hB,
    OP_AND  = 4'hC,
    OP_OR   = 4'hD,
    OP_XOR  = 4'hE,
    OP_PASS = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// WIDTH-iteration shift-add unsigned multiplier; done_c pulses for one cycle
// once the full 2*WIDTH product is present.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   sum_c;

  // Upper half accumulates the multiplicand when the multiplier LSB is set.
  assign sum_c  = {1'b0, product[2*WIDTH-1:WIDTH]}
                + {1'b0, (product[0] ? mcand : {WIDTH{1'b0}})};
  assign done_c = busy && (cnt == CNT_W'(WIDTH));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy    <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      product <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= '0;
      mcand   <= a;
      product <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      if (cnt == CNT_W'(WIDTH)) begin
        busy <= 1'b0;
      end else begin
        product <= {sum_c, product[WIDTH-1:1]};
        cnt     <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops registered directly, multiply via the
// shift-add sub-module; result and flags held until the consumer accepts.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     IN_A,
  input  logic [WIDTH-1:0]     IN_B,
  input  logic [OP_W-1:0]      ALU_OP,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [WIDTH-1:0]     OUT_RESULT,
  output logic [WIDTH-1:0]     OUT_RESULT_HI,
  output logic [NUM_FLAGS-1:0] OUT_FLAGS
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e                 state_q, state_d;
  alu_op_e                op;
  logic                   xfer_c, mul_start_c, mul_done_c;
  logic [2*WIDTH-1:0]     product;
  logic [WIDTH-1:0]       x, y, arith_res, alu_res;
  logic                   is_sub, arith_c, arith_v, alu_c, alu_v;
  logic [WIDTH:0]         sum_c, diff_c, shl_c, shr_c;
  logic [SHW-1:0]         shamt;
  logic [NUM_FLAGS-1:0]   alu_flags, mul_flags;
  logic                   out_valid_d;
  logic [WIDTH-1:0]       result_d, result_hi_d;
  logic [NUM_FLAGS-1:0]   flags_d;

  assign op       = alu_op_e'(ALU_OP);
  assign IN_READY = (state_q == IDLE) || ((state_q == DONE) && OUT_READY);
  assign xfer_c   = IN_VALID && IN_READY;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .start   (mul_start_c),
    .a       (IN_A),
    .b       (IN_B),
    .done_c  (mul_done_c),
    .product (product)
  );

  // Operand selection so add/sub/inc/dec share one adder and one subtractor.
  always_comb begin
    x      = IN_A;
    y      = IN_B;
    is_sub = 1'b0;
    case (op)
      OP_SUB:  is_sub = 1'b1;
      OP_INCA: y = WIDTH'(1);
      OP_INCB: begin x = IN_B; y = WIDTH'(1); end
      OP_DECA: begin y = WIDTH'(1); is_sub = 1'b1; end
      OP_DECB: begin x = IN_B; y = WIDTH'(1); is_sub = 1'b1; end
      default: ;
    endcase
  end

  assign sum_c     = {1'b0, x} + {1'b0, y};
  assign diff_c    = {1'b0, x} - {1'b0, y};
  assign arith_res = is_sub ? diff_c[WIDTH-1:0] : sum_c[WIDTH-1:0];
  assign arith_c   = is_sub ? diff_c[WIDTH] : sum_c[WIDTH];
  assign arith_v   = (is_sub ? (x[WIDTH-1] != y[WIDTH-1]) : (x[WIDTH-1] == y[WIDTH-1]))
                     && (arith_res[WIDTH-1] != x[WIDTH-1]);

  // The extra bit beyond the result holds the last bit shifted out.
  assign shamt = IN_B[SHW-1:0];
  assign shl_c = {1'b0, IN_A} << shamt;
  assign shr_c = {IN_A, 1'b0} >> shamt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_INCA, OP_INCB, OP_DECA, OP_DECB: begin
        alu_res = arith_res;
        alu_c   = arith_c;
        alu_v   = arith_v;
      end
      OP_SHL:  begin alu_res = shl_c[WIDTH-1:0]; alu_c = shl_c[WIDTH]; end
      OP_SHR:  begin alu_res = shr_c[WIDTH:1];   alu_c = shr_c[0];     end
      OP_EQ:   alu_res = WIDTH'(IN_A == IN_B);
      OP_GT:   alu_res = WIDTH'(IN_A > IN_B);
      OP_LT:   alu_res = WIDTH'(IN_A < IN_B);
      OP_AND:  alu_res = IN_A & IN_B;
      OP_OR:   alu_res = IN_A | IN_B;
      OP_XOR:  alu_res = IN_A ^ IN_B;
      OP_PASS: alu_res = IN_A;
      default: ;
    endcase
  end

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (product == '0);
    mul_flags[FLAG_C] = |product[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_N] = product[WIDTH-1];
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = OUT_VALID;
    result_d    = OUT_RESULT;
    result_hi_d = OUT_RESULT_HI;
    flags_d     = OUT_FLAGS;
    mul_start_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && OUT_READY) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
        if (xfer_c) begin
          if (op == OP_MUL) begin
            state_d     = MUL;
            mul_start_c = 1'b1;
            out_valid_d = 1'b0;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            flags_d     = alu_flags;
          end
        end
      end
      MUL: begin
        if (mul_done_c) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = product[WIDTH-1:0];
          result_hi_d = product[2*WIDTH-1:WIDTH];
          flags_d     = mul_flags;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      OUT_VALID     <= 1'b0;
      OUT_RESULT    <= '0;
      OUT_RESULT_HI <= '0;
      OUT_FLAGS     <= '0;
    end else begin
      state_q       <= state_d;
      OUT_VALID     <= out_valid_d;
      OUT_RESULT    <= result_d;
      OUT_RESULT_HI <= result_hi_d;
      OUT_FLAGS     <= flags_d;
    end
  end

endmodule
